branch_predict_unit: RTL

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit_pkg.sv | 25 ++
 rtl/branch_predict_unit_cond.sv | 37 +++
 rtl/branch_predict_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: branch codes, 2-bit counter states and counter update helper
package branch_predict_unit_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        return taken ? ((c == ST) ? ST : ctr_t'(c + 2'd1))
                     : ((c == SNT) ? SNT : ctr_t'(c - 2'd1));
    endfunction

endpackage

// File: rtl/branch_predict_unit_cond.sv
// branch_cond: combinational branch outcome evaluation for conditional branch funct3 codes
module branch_cond
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    logic eq;
    logic lts;
    logic ltu;

    assign eq  = a == b;
    assign lts = $signed(a) < $signed(b);
    assign ltu = a < b;

    // decode funct3; unsupported codes resolve as not-taken and flag illegal
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lts;
            F3_BGE:  taken = !lts;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: bimodal 2-bit predictor with one-cycle branch resolve and statistics
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [XLEN-1:0]   res_pc,
    input  logic [XLEN-1:0]   res_a,
    input  logic [XLEN-1:0]   res_b,
    input  logic [2:0]        res_funct3,
    input  logic              res_pred,
    output logic              out_valid,
    output logic              out_taken,
    output logic              out_mispredict,
    output logic              out_illegal,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDXW = $clog2(BHT_DEPTH);

    ctr_t            bht [BHT_DEPTH];
    logic [IDXW-1:0] pred_idx;
    logic [IDXW-1:0] res_idx;
    logic            taken;
    logic            illegal;
    logic            legal;
    logic            mis;
    logic            unused_pc;

    // word-aligned PC bits select the entry; upper bits alias with no tag
    assign pred_idx  = pred_pc[IDXW+1:2];
    assign res_idx   = res_pc[IDXW+1:2];
    assign unused_pc = ^{pred_pc[XLEN-1:IDXW+2], pred_pc[1:0], res_pc[XLEN-1:IDXW+2], res_pc[1:0]};

    branch_cond #(.XLEN(XLEN)) u_cond (
        .a       (res_a),
        .b       (res_b),
        .funct3  (res_funct3),
        .taken   (taken),
        .illegal (illegal)
    );

    assign legal      = res_valid && !illegal;
    assign mis        = legal && (taken != res_pred);
    assign pred_taken = bht[pred_idx][1];

    // counter table: reset to weakly not-taken, train on legal resolves (read-before-write)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= WNT;
        end else if (legal) begin
            bht[res_idx] <= ctr_next(bht[res_idx], taken);
        end
    end

    // registered resolve result, forced to zero when no request was accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
        end else begin
            out_valid      <= res_valid;
            out_taken      <= res_valid && taken;
            out_mispredict <= mis;
            out_illegal    <= res_valid && illegal;
        end
    end

    // saturating event counters for legal branches and their mispredictions
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_branches    <= stat_branches + STAT_W'(legal && (stat_branches != '1));
            stat_mispredicts <= stat_mispredicts + STAT_W'(mis && (stat_mispredicts != '1));
        end
    end

endmodule
